// File: rtl/i2s_tx.sv
// i2s_tx: I2S frame serialiser timed by clk_div enables; define I2S_TX_LEFT_JUSTIFIED_EN for left-justified format
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                    master_clk,
    input  logic                    rst,
    input  logic                    sample_clk_en,
    input  logic                    bit_clk_en,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    tx_mute,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    sample_latched,
    output logic                    sync_err
);
    localparam int PW = $clog2(2 * SLOT_WIDTH);
    localparam int CW = $clog2(4 * SLOT_WIDTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(4 * SLOT_WIDTH);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic IDLE_LR = 1'b1;
`else
    localparam logic IDLE_LR = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [CW-1:0] pcnt;
    logic [PW-1:0] pos;
    logic [SAMPLE_WIDTH-1:0] left_q;
    logic [SAMPLE_WIDTH-1:0] right_q;
    logic mute_q;

    function automatic logic lr_of(input logic [PW-1:0] p);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        return int'(p) < SLOT_WIDTH;
`else
        return int'(p) >= SLOT_WIDTH;
`endif
    endfunction

    // Out-of-range shift amounts land outside the guarded slot window, so the shift result is never used there
    function automatic logic bit_of(input logic [PW-1:0] p, input logic [SAMPLE_WIDTH-1:0] l,
                                    input logic [SAMPLE_WIDTH-1:0] r, input logic m);
        int s;
        logic [SAMPLE_WIDTH-1:0] w;
        s = int'(p) % SLOT_WIDTH;
        w = (int'(p) >= SLOT_WIDTH) ? r : l;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        w = w >> (SAMPLE_WIDTH - 1 - s);
        return !m && s < SAMPLE_WIDTH && w[0];
`else
        w = w >> (SAMPLE_WIDTH - s);
        return !m && s >= 1 && s <= SAMPLE_WIDTH && w[0];
`endif
    endfunction

    always_ff @(posedge master_clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt <= '0;
            pos <= '0;
            left_q <= '0;
            right_q <= '0;
            mute_q <= 1'b0;
            i2s_bclk <= 1'b0;
            i2s_lrclk <= IDLE_LR;
            i2s_sdata <= 1'b0;
            sample_latched <= 1'b0;
            sync_err <= 1'b0;
        end else if (sample_clk_en) begin
            sync_err <= state == RUN && pcnt != FULL;
            state <= RUN;
            pcnt <= CW'(1);
            pos <= '0;
            left_q <= sample_left;
            right_q <= sample_right;
            mute_q <= tx_mute;
            i2s_bclk <= 1'b0;
            i2s_lrclk <= lr_of('0);
            i2s_sdata <= bit_of('0, sample_left, sample_right, tx_mute);
            sample_latched <= 1'b1;
        end else begin
            sample_latched <= 1'b0;
            sync_err <= 1'b0;
            // Odd pulses raise bclk; even pulses drop it and advance to the next bit
            if (state == RUN && bit_clk_en && pcnt < FULL) begin
                pcnt <= pcnt + 1'b1;
                i2s_bclk <= pcnt[0];
                if (!pcnt[0]) begin
                    pos <= pos + 1'b1;
                    i2s_lrclk <= lr_of(pos + 1'b1);
                    i2s_sdata <= bit_of(pos + 1'b1, left_q, right_q, mute_q);
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with a pulse-count frame model checked every cycle
module tb_i2s_tx;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif
    logic master_clk = 1'b0;
    logic rst = 1'b1;
    logic sample_clk_en = 1'b0;
    logic bit_clk_en = 1'b0;
    logic tx_mute = 1'b0;
    logic [15:0] sample_left = '0;
    logic [15:0] sample_right = '0;
    logic i2s_bclk, i2s_lrclk, i2s_sdata, sample_latched, sync_err;

    int checks = 0;
    int errors = 0;
    bit chk = 1'b0;

    always #5 master_clk = ~master_clk;

    i2s_tx dut (
        .master_clk(master_clk),
        .rst(rst),
        .sample_clk_en(sample_clk_en),
        .bit_clk_en(bit_clk_en),
        .sample_left(sample_left),
        .sample_right(sample_right),
        .tx_mute(tx_mute),
        .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata),
        .sample_latched(sample_latched),
        .sync_err(sync_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the latched samples plus k, the number of accepted enable pulses (start = pulse 0)
    bit m_run = 1'b0;
    int m_k = 0;
    logic [15:0] m_l = '0, m_r = '0;
    logic m_m = 1'b0, m_lat = 1'b0, m_err = 1'b0;

    always @(posedge master_clk) begin
        if (rst) begin
            m_run <= 1'b0;
            m_k <= 0;
            m_lat <= 1'b0;
            m_err <= 1'b0;
        end else if (sample_clk_en) begin
            m_err <= m_run && m_k < 128;
            m_run <= 1'b1;
            m_k <= 1;
            m_l <= sample_left;
            m_r <= sample_right;
            m_m <= tx_mute;
            m_lat <= 1'b1;
        end else begin
            m_lat <= 1'b0;
            m_err <= 1'b0;
            if (m_run && bit_clk_en && m_k < 128) m_k <= m_k + 1;
        end
    end

    function automatic logic exp_bit(input int p, input logic [15:0] l, input logic [15:0] r, input logic m);
        int s;
        logic [15:0] w;
        s = p % 32;
        w = p >= 32 ? r : l;
        if (m) return 1'b0;
        if (LJ) return s < 16 ? w[4'(15 - s)] : 1'b0;
        return (s >= 1 && s <= 16) ? w[4'(16 - s)] : 1'b0;
    endfunction

    int cap_n = 0, lat_cnt = 0, err_cnt = 0, p;
    logic [63:0] cap_sd = '0, cap_lr = '0;
    logic prev_b = 1'b0;

    always @(negedge master_clk) if (chk) begin
        p = (m_k - 1) / 2;
        check("bclk", i2s_bclk, m_run ? 1'(m_k % 2 == 0) : 1'b0);
        check("lrclk", i2s_lrclk, m_run ? (LJ ? 1'(p < 32) : 1'(p >= 32)) : LJ);
        check("sdata", i2s_sdata, m_run ? exp_bit(p, m_l, m_r, m_m) : 1'b0);
        check("sample_latched", sample_latched, m_lat);
        check("sync_err", sync_err, m_err);
        if (m_lat) begin
            cap_n = 0;
            cap_sd = '0;
            cap_lr = '0;
        end
        if (!prev_b && i2s_bclk) begin
            cap_sd = {cap_sd[62:0], i2s_sdata};
            cap_lr = {cap_lr[62:0], i2s_lrclk};
            cap_n++;
        end
        prev_b = i2s_bclk;
        if (sample_latched) lat_cnt++;
        if (sync_err) err_cnt++;
    end

    task automatic clr();
        cap_n = 0;
        lat_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic pulse();
        bit_clk_en = 1'b1;
        @(negedge master_clk);
        bit_clk_en = 1'b0;
        repeat (3) @(negedge master_clk);
    endtask

    task automatic pulses(input int n);
        repeat (n) pulse();
    endtask

    task automatic start(input logic [15:0] l, input logic [15:0] r, input logic m, input logic b);
        sample_left = l;
        sample_right = r;
        tx_mute = m;
        sample_clk_en = 1'b1;
        bit_clk_en = b;
        @(negedge master_clk);
        sample_clk_en = 1'b0;
        bit_clk_en = 1'b0;
        repeat (3) @(negedge master_clk);
    endtask

    task automatic frame_check(input string name, input logic [63:0] exp_sd);
        #1;
        check({name, "_bits"}, 64'(cap_n), 64'd64);
        check({name, "_data"}, cap_sd, exp_sd);
        check({name, "_lr"}, cap_lr, LJ ? 64'hFFFFFFFF_00000000 : 64'h00000000_FFFFFFFF);
    endtask

    initial begin
        @(negedge master_clk);
        chk = 1'b1;
        @(negedge master_clk);
        #1;
        check("rst_bclk", i2s_bclk, 1'b0);
        check("rst_lrclk", i2s_lrclk, LJ);
        check("rst_sdata", i2s_sdata, 1'b0);
        check("rst_latched", sample_latched, 1'b0);
        check("rst_sync_err", sync_err, 1'b0);
        @(negedge master_clk);
        rst = 1'b0;
        // Enables before any frame start are ignored
        pulses(10);
        #1;
        check("pre_no_bclk", 64'(cap_n), 64'd0);
        clr();
        @(negedge master_clk);
        start(16'hA5C3, 16'h0001, 1'b0, 1'b0);
        pulses(128);
        frame_check("basic", LJ ? 64'hA5C30000_00010000 : 64'h52E18000_00008000);
        check("basic_latched_cnt", 64'(lat_cnt), 64'd1);
        check("basic_sync_err_cnt", 64'(err_cnt), 64'd0);
        clr();
        @(negedge master_clk);
        // Back-to-back frames with start coincident with a bit enable
        for (int f = 0; f < 3; f++) begin
            start(16'h1234, 16'h8000, 1'b0, 1'b1);
            pulses(126);
            bit_clk_en = 1'b1;
            @(negedge master_clk);
            bit_clk_en = 1'b0;
            repeat (2) @(negedge master_clk);
            #1;
            check("b2b_end_bclk", i2s_bclk, 1'b1);
            check("b2b_bits", 64'(cap_n), 64'd64);
            @(negedge master_clk);
        end
        #1;
        check("b2b_data", cap_sd, LJ ? 64'h12340000_80000000 : 64'h091A0000_40000000);
        check("b2b_latched_cnt", 64'(lat_cnt), 64'd3);
        check("b2b_sync_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge master_clk);
        // Mute latched at frame start holds even after deassertion
        start(16'h7FFF, 16'h1234, 1'b1, 1'b0);
        pulses(10);
        tx_mute = 1'b0;
        sample_left = 16'hFFFF;
        pulses(118);
        frame_check("mute", 64'h0);
        @(negedge master_clk);
        start(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        pulses(128);
        frame_check("unmute", LJ ? 64'h7FFF0000_FFFF0000 : 64'h3FFF8000_7FFF8000);
        clr();
        @(negedge master_clk);
        // Early restart
        start(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        pulses(100);
        start(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
        pulses(128);
        frame_check("early", LJ ? 64'h0F0F0000_F0F00000 : 64'h07878000_78780000);
        check("early_sync_err_cnt", 64'(err_cnt), 64'd1);
        check("early_latched_cnt", 64'(lat_cnt), 64'd2);
        clr();
        @(negedge master_clk);
        // Reset at pos 20
        start(16'h1111, 16'h2222, 1'b0, 1'b0);
        pulses(40);
        rst = 1'b1;
        @(negedge master_clk);
        rst = 1'b0;
        #1;
        check("midrst_bclk", i2s_bclk, 1'b0);
        check("midrst_lrclk", i2s_lrclk, LJ);
        check("midrst_sdata", i2s_sdata, 1'b0);
        check("midrst_latched", sample_latched, 1'b0);
        clr();
        @(negedge master_clk);
        pulses(10);
        #1;
        check("midrst_no_bclk", 64'(cap_n), 64'd0);
        clr();
        @(negedge master_clk);
        start(16'h3333, 16'h4444, 1'b0, 1'b0);
        pulses(128);
        frame_check("after_rst", LJ ? 64'h33330000_44440000 : 64'h19998000_22220000);
        check("after_rst_sync_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge master_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
